morse_tx_fifo: RTL

//  Parametrised ASCII-to-Morse transmitter: buffers characters in a DEPTH-entry FIFO, encodes
//  A-Z/a-z/0-9/space to ITU Morse and keys a single on/off output.

---
 rtl/morse_tx_fifo_pkg.sv | 87 ++++++++
 rtl/morse_tx_fifo_fifo.sv | 82 ++++++++
 rtl/morse_tx_fifo.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/morse_tx_fifo_pkg.sv
// =============================================================================
// Module      : morse_tx_fifo_pkg
// Description : State encoding, unit constants and the ASCII-to-Morse lookup
//               shared by the Morse transmitter files.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package morse_tx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MARK = 3'd2,
        ST_EGAP = 3'd3,
        ST_CGAP = 3'd4,
        ST_WGAP = 3'd5
    } state_e;

    localparam logic [2:0] c_dot_units        = 3'd1;
    localparam logic [2:0] c_dash_units       = 3'd3;
    localparam logic [2:0] c_egap_units       = 3'd1;
    localparam logic [2:0] c_cgap_units       = 3'd3;
    localparam logic [2:0] c_wgap_extra_units = 3'd4;
    localparam logic [7:0] c_ascii_space      = 8'h20;

    // bits are left-aligned: bits[4] is the first element, 1 = dash
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] bits;
    } morse_code_t;

    function automatic logic [7:0] fold_case(input logic [7:0] ch);
        if (ch >= 8'h61 && ch <= 8'h7A) begin
            return ch - 8'h20;
        end
        return ch;
    endfunction

    function automatic morse_code_t morse_lut(input logic [7:0] ch);
        morse_code_t c;
        c = '0;
        case (fold_case(ch))
            "A": c = {3'd2, 5'b01000};
            "B": c = {3'd4, 5'b10000};
            "C": c = {3'd4, 5'b10100};
            "D": c = {3'd3, 5'b10000};
            "E": c = {3'd1, 5'b00000};
            "F": c = {3'd4, 5'b00100};
            "G": c = {3'd3, 5'b11000};
            "H": c = {3'd4, 5'b00000};
            "I": c = {3'd2, 5'b00000};
            "J": c = {3'd4, 5'b01110};
            "K": c = {3'd3, 5'b10100};
            "L": c = {3'd4, 5'b01000};
            "M": c = {3'd2, 5'b11000};
            "N": c = {3'd2, 5'b10000};
            "O": c = {3'd3, 5'b11100};
            "P": c = {3'd4, 5'b01100};
            "Q": c = {3'd4, 5'b11010};
            "R": c = {3'd3, 5'b01000};
            "S": c = {3'd3, 5'b00000};
            "T": c = {3'd1, 5'b10000};
            "U": c = {3'd3, 5'b00100};
            "V": c = {3'd4, 5'b00010};
            "W": c = {3'd3, 5'b01100};
            "X": c = {3'd4, 5'b10010};
            "Y": c = {3'd4, 5'b10110};
            "Z": c = {3'd4, 5'b11000};
            "0": c = {3'd5, 5'b11111};
            "1": c = {3'd5, 5'b01111};
            "2": c = {3'd5, 5'b00111};
            "3": c = {3'd5, 5'b00011};
            "4": c = {3'd5, 5'b00001};
            "5": c = {3'd5, 5'b00000};
            "6": c = {3'd5, 5'b10000};
            "7": c = {3'd5, 5'b11000};
            "8": c = {3'd5, 5'b11100};
            "9": c = {3'd5, 5'b11110};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/morse_tx_fifo_fifo.sv
// =============================================================================
// Module      : morse_tx_fifo_fifo
// Description : Synchronous FIFO holding characters awaiting transmission.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module morse_tx_fifo_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             w_push;
    logic             w_pop;

    // a push is refused while full even when a pop frees a slot this cycle
    assign w_push = push_i && !full_q;
    assign w_pop  = pop_i  && !empty_q;

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

`default_nettype wire

// File: rtl/morse_tx_fifo.sv
// =============================================================================
// Module      : morse_tx_fifo
// Description : Buffered ASCII-to-Morse transmitter keying a single on/off output.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module morse_tx_fifo #(
    parameter int PRESCALER = 100,
    parameter int DEPTH     = 8,
    parameter int DIV_W     = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             write_en,
    input  logic [7:0]       ascii_in,
    input  logic [DIV_W-1:0] unit_div,
    input  logic             clr_ovf,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             overflow,
    output logic             morse_out
);

    import morse_tx_fifo_pkg::*;

    localparam int               CW             = $clog2(DEPTH) + 1;
    localparam logic [DIV_W-1:0] c_default_unit = DIV_W'(PRESCALER);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] unit_q, unit_d;
    logic [DIV_W-1:0] cyc_q, cyc_d;
    logic [2:0]       units_q, units_d;
    logic [4:0]       code_q, code_d;
    logic [2:0]       rem_q, rem_d;
    logic             overflow_q, overflow_d;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [7:0]       w_head;
    logic [CW-1:0]    w_count;
    logic             w_valid_wr;
    logic             w_push;
    logic             w_drop;
    logic             w_load;
    logic             w_tick;
    logic             w_done;
    logic [2:0]       w_period;
    morse_code_t      w_head_code;
    logic             w_head_space;

    assign w_valid_wr = write_en && (ascii_in != 8'h00);
    assign w_push     = w_valid_wr && !w_fifo_full;
    assign w_drop     = w_valid_wr &&  w_fifo_full;

    morse_tx_fifo_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .push_i  (w_push),
        .pop_i   (w_load),
        .din_i   (ascii_in),
        .dout_o  (w_head),
        .count_o (w_count),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign w_head_code  = morse_lut(w_head);
    assign w_head_space = (w_head == c_ascii_space);

    always_comb begin
        w_period = c_dot_units;
        case (state_q)
            ST_MARK: w_period = code_q[4] ? c_dash_units : c_dot_units;
            ST_EGAP: w_period = c_egap_units;
            ST_CGAP: w_period = c_cgap_units;
            ST_WGAP: w_period = c_wgap_extra_units;
            default: w_period = c_dot_units;
        endcase
    end

    assign w_tick = (cyc_q == unit_q - DIV_W'(1));
    assign w_done = w_tick && (units_q == w_period - 3'd1);

    // Gap expiry loads the next character in the same cycle so that
    // back-to-back characters see no extra LOAD cycle.
    always_comb begin
        state_d = state_q;
        w_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load = 1'b1;
            end
            ST_MARK: begin
                if (w_done) begin
                    state_d = (rem_q > 3'd1) ? ST_EGAP : ST_CGAP;
                end
            end
            ST_EGAP: begin
                if (w_done) begin
                    state_d = ST_MARK;
                end
            end
            ST_CGAP, ST_WGAP: begin
                if (w_done) begin
                    if (!w_fifo_empty) begin
                        w_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_load) begin
            if (w_head_code.len != 3'd0) begin
                state_d = ST_MARK;
            end else if (w_head_space) begin
                state_d = ST_WGAP;
            end else if (w_count > CW'(1)) begin
                state_d = ST_LOAD;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        unit_d     = unit_q;
        code_d     = code_q;
        rem_d      = rem_q;
        cyc_d      = cyc_q;
        units_d    = units_q;
        overflow_d = overflow_q;

        if (w_load) begin
            unit_d = (unit_div == '0) ? c_default_unit : unit_div;
            code_d = w_head_code.bits;
            rem_d  = w_head_code.len;
        end else if (state_q == ST_MARK && w_done) begin
            code_d = code_q << 1;
            rem_d  = rem_q - 3'd1;
        end

        // every period, including a space following a space, starts from zero
        if (w_load || (state_d != state_q)) begin
            cyc_d   = '0;
            units_d = '0;
        end else if (w_tick) begin
            cyc_d   = '0;
            units_d = units_q + 3'd1;
        end else begin
            cyc_d = cyc_q + DIV_W'(1);
        end

        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (w_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            unit_q     <= c_default_unit;
            code_q     <= '0;
            rem_q      <= '0;
            cyc_q      <= '0;
            units_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            unit_q     <= unit_d;
            code_q     <= code_d;
            rem_q      <= rem_d;
            cyc_q      <= cyc_d;
            units_q    <= units_d;
            overflow_q <= overflow_d;
        end
    end

    assign morse_out = (state_q == ST_MARK);
    assign busy      = (state_q != ST_IDLE);
    assign full      = w_fifo_full;
    assign empty     = w_fifo_empty;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire
